posit_pack_seq: RTL

POSIT_PACK_SEQ -- requirements
Module: posit_pack_seq

---
 rtl/posit_pkg.sv | 38 +++
 rtl/posit_round_rne.sv | 47 ++++
 rtl/posit_pack_seq.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/posit_pkg.sv
// posit_pkg: definitions shared by the posit packer.
// Contents:
//   state_t      - packer FSM states (IDLE, SHIFT, ROUND, DONE)
//   log2_ceil()  - ceiling log2, used for default width parameters
//   maxpos_of()  - largest positive posit pattern of a given width
//   minpos_of()  - smallest positive posit pattern of a given width
//   nar_of()     - Not-a-Real / infinity pattern of a given width
package posit_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic int log2_ceil(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   function automatic logic [63:0] maxpos_of(input int n);
      return (64'd1 << (n - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] minpos_of(input int n);
      return 64'd1 + 64'(n - n);
   endfunction

   function automatic logic [63:0] nar_of(input int n);
      return 64'd1 << (n - 1);
   endfunction

endpackage

// File: rtl/posit_round_rne.sv
// posit_round_rne: combinational round-to-nearest-even of a posit magnitude,
// with saturation to the posit range (never rounds to zero or into the sign).
// Ports:
//   mag      - N-1 magnitude bits before rounding
//   guard    - first bit below the magnitude LSB
//   sticky   - OR of all bits below the guard bit
//   sat_max  - regime too large: force maxpos
//   sat_min  - regime too small: force minpos
//   res      - rounded N-1 bit magnitude
module posit_round_rne
   import posit_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-2:0] mag,
   input  logic         guard,
   input  logic         sticky,
   input  logic         sat_max,
   input  logic         sat_min,
   output logic [N-2:0] res
);

   localparam int MW = N - 1;
   localparam logic [N-2:0] MAXMAG = MW'(maxpos_of(N));
   localparam logic [N-2:0] MINMAG = MW'(minpos_of(N));

   logic         round_up;
   logic [N-1:0] sum;

   always_comb begin
      round_up = guard & (sticky | mag[0]);
      sum      = {1'b0, mag} + {{MW{1'b0}}, round_up};
      if (sat_max) begin
         res = MAXMAG;
      end else if (sat_min) begin
         res = MINMAG;
      end else if (sum[N-1]) begin
         // carry would reach the sign bit
         res = MAXMAG;
      end else if (sum[N-2:0] == '0) begin
         res = MINMAG;
      end else begin
         res = sum[N-2:0];
      end
   end

endmodule

// File: rtl/posit_pack_seq.sv
// posit_pack_seq: sequential posit packer. Builds the regime run bit by bit,
// then rounds (RNE) and applies the sign.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start               - pack request (accepted in IDLE or DONE only)
//   in_s, in_r          - sign, signed regime value k
//   in_e, in_m          - exponent, MSB-aligned fraction (hidden bit excluded)
//   in_zero, in_inf     - special values (inf has priority)
//   out, zero, inf      - packed posit and special flags, held while in DONE
//   busy, done          - operation in flight / result valid
module posit_pack_seq
   import posit_pkg::*;
#(
   parameter int N  = 8,
   parameter int es = 4,
   parameter int Bs = log2_ceil(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          in_s,
   input  logic [Bs:0]   in_r,
   input  logic [es-1:0] in_e,
   input  logic [N-1:0]  in_m,
   input  logic          in_zero,
   input  logic          in_inf,
   output logic [N-1:0]  out,
   output logic          zero,
   output logic          inf,
   output logic          busy,
   output logic          done
);

   localparam int MW = N - 1;
   localparam int WW = MW + es + N;
   localparam logic [N-1:0] NAR = N'(nar_of(N));

   state_t        state_q, state_d;
   logic          accept;

   int            k_int, l_int;
   logic [Bs-1:0] l_val;
   logic          k_sat_max, k_sat_min;

   logic [WW-1:0] wreg_q;
   logic [Bs-1:0] cnt_q;
   logic          first_q, neg_k_q;
   logic          sat_max_q, sat_min_q;
   logic          sgn_q, zin_q, iin_q;
   logic          rnd_ph_q;
   logic [MW-1:0] res_q;
   logic [MW-1:0] rnd_mag;
   logic          ins_bit;
   logic [N-1:0]  mag_ext;

   // Regime length including terminator, clamped to the magnitude width.
   always_comb begin
      k_int = int'($signed(in_r));
      l_int = (k_int >= 0) ? (k_int + 2) : (1 - k_int);
      if (l_int > N - 1) l_int = N - 1;
      l_val     = Bs'(l_int);
      k_sat_max = (k_int >= N - 2);
      k_sat_min = (k_int <= -(N - 1));
   end

   assign accept = start && ((state_q == IDLE) || (state_q == DONE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            done = (state_q == DONE);
            if (start) state_d = (in_zero || in_inf) ? ROUND : SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            if (cnt_q == Bs'(1)) state_d = ROUND;
         end
         ROUND: begin
            busy = 1'b1;
            if (rnd_ph_q) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   // The terminator enters first so it ends up just above the exponent;
   // the run bits follow, pushing it down one position per cycle.
   assign ins_bit = first_q ? neg_k_q : ~neg_k_q;

   posit_round_rne #(.N(N)) u_round (
      .mag     (wreg_q[WW-1 -: MW]),
      .guard   (wreg_q[WW-1-MW]),
      .sticky  (|wreg_q[WW-2-MW:0]),
      .sat_max (sat_max_q),
      .sat_min (sat_min_q),
      .res     (rnd_mag)
   );

   assign mag_ext = {1'b0, res_q};

   // ROUND spans two cycles: the first registers the rounder result,
   // the second applies sign/specials and publishes on DONE entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wreg_q    <= '0;
         cnt_q     <= '0;
         first_q   <= 1'b0;
         neg_k_q   <= 1'b0;
         sat_max_q <= 1'b0;
         sat_min_q <= 1'b0;
         sgn_q     <= 1'b0;
         zin_q     <= 1'b0;
         iin_q     <= 1'b0;
         rnd_ph_q  <= 1'b0;
         res_q     <= '0;
         out       <= '0;
         zero      <= 1'b0;
         inf       <= 1'b0;
      end else if (accept) begin
         wreg_q    <= {in_e, in_m, {MW{1'b0}}};
         cnt_q     <= l_val;
         first_q   <= 1'b1;
         neg_k_q   <= in_r[Bs];
         sat_max_q <= k_sat_max;
         sat_min_q <= k_sat_min;
         sgn_q     <= in_s;
         zin_q     <= in_zero;
         iin_q     <= in_inf;
         rnd_ph_q  <= 1'b0;
      end else begin
         case (state_q)
            SHIFT: begin
               wreg_q  <= {ins_bit, wreg_q[WW-1:1]};
               cnt_q   <= cnt_q - Bs'(1);
               first_q <= 1'b0;
            end
            ROUND: begin
               rnd_ph_q <= ~rnd_ph_q;
               if (!rnd_ph_q) begin
                  res_q <= rnd_mag;
               end else if (iin_q) begin
                  out  <= NAR;
                  zero <= 1'b0;
                  inf  <= 1'b1;
               end else if (zin_q) begin
                  out  <= '0;
                  zero <= 1'b1;
                  inf  <= 1'b0;
               end else begin
                  out  <= sgn_q ? ((~mag_ext) + N'(1)) : mag_ext;
                  zero <= 1'b0;
                  inf  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
